decode_queue_stage: RTL and testbench

//  Registered RV32I decode stage with an instruction queue between IF and ID/EX. Buffers up to DEPTH
//  {instr, pc} pairs from fetch, decodes the head and presents decode results in a valid/ready output register.

---
 rtl/decode_queue_stage_if.sv | 47 ++++
 rtl/decode_queue_stage.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_decode_queue_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_stage_if.sv
// Fetch-side and decode-side handshake bundle for decode_queue_stage.
// The slave modport is the stage itself; the master modport is its environment.
interface decode_queue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_jal;
  logic            out_jalr;
  logic [2:0]      out_reg_write;
  logic            out_mem_to_reg;
  logic [3:0]      out_mem_write;
  logic            out_load_npc;
  logic [1:0]      out_reg_read;
  logic [2:0]      out_branch_type;
  logic [3:0]      out_alu_ctrl;
  logic            out_alu_src1;
  logic [1:0]      out_alu_src2;
  logic [2:0]      out_imm_type;
  logic            out_illegal;
  logic [3:0]      out_md_op;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_jal, out_jalr,
           out_reg_write, out_mem_to_reg, out_mem_write, out_load_npc, out_reg_read,
           out_branch_type, out_alu_ctrl, out_alu_src1, out_alu_src2, out_imm_type,
           out_illegal, out_md_op
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_jal, out_jalr,
           out_reg_write, out_mem_to_reg, out_mem_write, out_load_npc, out_reg_read,
           out_branch_type, out_alu_ctrl, out_alu_src1, out_alu_src2, out_imm_type,
           out_illegal, out_md_op
  );
endinterface

// File: rtl/decode_queue_stage.sv
// RV32I decode stage: DEPTH-entry {instr, pc} queue feeding a registered decoder with valid/ready output.
// Define RV32M_EN to accept and tag RV32M (mul/div) encodings; otherwise they decode as illegal.
module decode_queue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  decode_queue_stage_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  localparam logic [2:0] RW_NONE = 3'd0;
  localparam logic [2:0] RW_LB   = 3'd1;
  localparam logic [2:0] RW_LH   = 3'd2;
  localparam logic [2:0] RW_LW   = 3'd3;
  localparam logic [2:0] RW_LBU  = 3'd4;
  localparam logic [2:0] RW_LHU  = 3'd5;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic [2:0] reg_write;
    logic       mem_to_reg;
    logic [3:0] mem_write;
    logic       load_npc;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [2:0] imm_type;
    logic       illegal;
    logic [3:0] md_op;
  } dec_t;

  function automatic dec_t f_decode(input logic [31:0] ins);
    dec_t       d;
    logic       ok;
    logic [2:0] fn3;
    logic [6:0] fn7;
    d        = '0;
    ok       = 1'b1;
    fn3      = ins[14:12];
    fn7      = ins[31:25];
    d.alu_ctrl = ALU_ADD;
    case (ins[6:0])
      OPC_LUI: begin
        d.reg_write = RW_LW; d.alu_ctrl = ALU_LUI; d.alu_src2 = 2'b10; d.imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        d.reg_write = RW_LW; d.alu_src1 = 1'b1; d.alu_src2 = 2'b10; d.imm_type = IMM_U;
      end
      OPC_JAL: begin
        d.jal = 1'b1; d.reg_write = RW_LW; d.load_npc = 1'b1;
        d.alu_src1 = 1'b1; d.alu_src2 = 2'b10; d.imm_type = IMM_J;
      end
      OPC_JALR: begin
        d.jalr = 1'b1; d.reg_write = RW_LW; d.load_npc = 1'b1; d.reg_read = 2'b10;
        d.alu_src1 = 1'b1; d.alu_src2 = 2'b10; d.imm_type = IMM_I;
        if (fn3 != 3'b000) ok = 1'b0;
      end
      OPC_BRANCH: begin
        d.reg_read = 2'b11; d.imm_type = IMM_B;
        case (fn3)
          3'b000:  d.branch_type = BR_BEQ;
          3'b001:  d.branch_type = BR_BNE;
          3'b100:  d.branch_type = BR_BLT;
          3'b101:  d.branch_type = BR_BGE;
          3'b110:  d.branch_type = BR_BLTU;
          3'b111:  d.branch_type = BR_BGEU;
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.mem_to_reg = 1'b1; d.reg_read = 2'b10; d.alu_src2 = 2'b10; d.imm_type = IMM_I;
        case (fn3)
          3'b000:  d.reg_write = RW_LB;
          3'b001:  d.reg_write = RW_LH;
          3'b010:  d.reg_write = RW_LW;
          3'b100:  d.reg_write = RW_LBU;
          3'b101:  d.reg_write = RW_LHU;
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.reg_read = 2'b11; d.alu_src2 = 2'b10; d.imm_type = IMM_S;
        case (fn3)
          3'b000:  d.mem_write = 4'b0001;
          3'b001:  d.mem_write = 4'b0011;
          3'b010:  d.mem_write = 4'b1111;
          default: ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d.reg_write = RW_LW; d.reg_read = 2'b10; d.alu_src2 = 2'b10; d.imm_type = IMM_I;
        case (fn3)
          3'b000: d.alu_ctrl = ALU_ADD;
          3'b010: d.alu_ctrl = ALU_SLT;
          3'b011: d.alu_ctrl = ALU_SLTU;
          3'b100: d.alu_ctrl = ALU_XOR;
          3'b110: d.alu_ctrl = ALU_OR;
          3'b111: d.alu_ctrl = ALU_AND;
          3'b001: begin
            d.alu_ctrl = ALU_SLL; d.alu_src2 = 2'b01;
            if (fn7 != 7'b0000000) ok = 1'b0;
          end
          default: begin
            d.alu_src2 = 2'b01;
            if (fn7 == 7'b0000000)      d.alu_ctrl = ALU_SRL;
            else if (fn7 == 7'b0100000) d.alu_ctrl = ALU_SRA;
            else                        ok = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        d.reg_write = RW_LW; d.reg_read = 2'b11; d.alu_src2 = 2'b00; d.imm_type = IMM_R;
        if (fn7 == 7'b0000000) begin
          case (fn3)
            3'b000:  d.alu_ctrl = ALU_ADD;
            3'b001:  d.alu_ctrl = ALU_SLL;
            3'b010:  d.alu_ctrl = ALU_SLT;
            3'b011:  d.alu_ctrl = ALU_SLTU;
            3'b100:  d.alu_ctrl = ALU_XOR;
            3'b101:  d.alu_ctrl = ALU_SRL;
            3'b110:  d.alu_ctrl = ALU_OR;
            default: d.alu_ctrl = ALU_AND;
          endcase
        end else if (fn7 == 7'b0100000) begin
          case (fn3)
            3'b000:  d.alu_ctrl = ALU_SUB;
            3'b101:  d.alu_ctrl = ALU_SRA;
            default: ok = 1'b0;
          endcase
`ifdef RV32M_EN
        end else if (fn7 == 7'b0000001) begin
          // M ops carry their own unit select; the ALU result is ignored downstream
          d.md_op = {1'b1, fn3};
`endif
        end else begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [31:0]     r_instr_q [DEPTH];
  logic [XLEN-1:0] r_pc_q    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic            r_vld_p1;
  dec_t            r_dec_p1;
  logic [XLEN-1:0] r_pc_p1;
  logic [31:0]     r_instr_p1;

  logic w_in_ready;
  logic w_push;
  logic w_load;
  dec_t w_dec_p0;

  assign w_in_ready = (r_count < CNT_W'(DEPTH));
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_load     = (r_count != '0) & (~r_vld_p1 | bus.out_ready);
  assign w_dec_p0   = f_decode(r_instr_q[r_rd_ptr]);

  // p0: queue storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= bus.in_instr;
      r_pc_q[r_wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld_p1 <= 1'b0;
      r_dec_p1 <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_vld_p1 <= 1'b1;
        r_dec_p1 <= w_dec_p0;
      end else if (r_vld_p1 && bus.out_ready) begin
        r_vld_p1 <= 1'b0;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // p1: decode output register
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_pc_p1    <= r_pc_q[r_rd_ptr];
      r_instr_p1 <= r_instr_q[r_rd_ptr];
    end
  end

  assign count               = r_count;
  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = r_vld_p1;
  assign bus.out_pc          = r_pc_p1;
  assign bus.out_rd          = r_instr_p1[11:7];
  assign bus.out_rs1         = r_instr_p1[19:15];
  assign bus.out_rs2         = r_instr_p1[24:20];
  assign bus.out_jal         = r_dec_p1.jal;
  assign bus.out_jalr        = r_dec_p1.jalr;
  assign bus.out_reg_write   = r_dec_p1.reg_write;
  assign bus.out_mem_to_reg  = r_dec_p1.mem_to_reg;
  assign bus.out_mem_write   = r_dec_p1.mem_write;
  assign bus.out_load_npc    = r_dec_p1.load_npc;
  assign bus.out_reg_read    = r_dec_p1.reg_read;
  assign bus.out_branch_type = r_dec_p1.branch_type;
  assign bus.out_alu_ctrl    = r_dec_p1.alu_ctrl;
  assign bus.out_alu_src1    = r_dec_p1.alu_src1;
  assign bus.out_alu_src2    = r_dec_p1.alu_src2;
  assign bus.out_imm_type    = r_dec_p1.imm_type;
  assign bus.out_illegal     = r_dec_p1.illegal;
  assign bus.out_md_op       = r_dec_p1.md_op;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: queueing, backpressure, flush, reset and decode vectors.
module tb_decode_queue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  int         n_checks = 0;
  int         n_errs   = 0;

  decode_queue_stage_if #(.XLEN(32)) u_if ();

  decode_queue_stage #(.XLEN(32), .DEPTH(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (u_if),
    .count (count)
  );

  always #5 clk = ~clk;

  // {illegal, reg_write, mem_write, branch_type, alu_ctrl}
  localparam logic [31:0] TV_INS [9] = '{
    32'h0020A023, 32'h00208463, 32'h000100E7, 32'h40005013, 32'h20005013,
    32'h0000A003, 32'h00003003, 32'h00001063, 32'h12345037
  };
  localparam logic [14:0] TV_EXP [9] = '{
    {1'b0, 3'd0, 4'hF, 3'd0, 4'd3},
    {1'b0, 3'd0, 4'h0, 3'd1, 4'd3},
    {1'b0, 3'd3, 4'h0, 3'd0, 4'd3},
    {1'b0, 3'd3, 4'h0, 3'd0, 4'd2},
    {1'b1, 3'd0, 4'h0, 3'd0, 4'd0},
    {1'b0, 3'd3, 4'h0, 3'd0, 4'd3},
    {1'b1, 3'd0, 4'h0, 3'd0, 4'd0},
    {1'b0, 3'd0, 4'h0, 3'd2, 4'd3},
    {1'b0, 3'd3, 4'h0, 3'd0, 4'd10}
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one instruction through an empty queue with out_ready=1; leaves it in the output register
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    u_if.in_valid = 1'b1;
    u_if.in_instr = ins;
    u_if.in_pc    = pc;
    tick();
    u_if.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_instr = '0; u_if.in_pc = '0; u_if.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("rst_reg_write", 32'(u_if.out_reg_write), 32'd0);
    chk("rst_branch", 32'(u_if.out_branch_type), 32'd0);

    // T1: addi x1,x0,5 -- one edge into queue, next edge into output register
    u_if.out_ready = 1'b1;
    u_if.in_valid = 1'b1; u_if.in_instr = 32'h00500093; u_if.in_pc = 32'h100;
    tick();
    u_if.in_valid = 1'b0;
    chk("t1_count_e", 32'(count), 32'd1);
    chk("t1_valid_e", 32'(u_if.out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(u_if.out_valid), 32'd1);
    chk("t1_pc", u_if.out_pc, 32'h100);
    chk("t1_rd", 32'(u_if.out_rd), 32'd1);
    chk("t1_alu", 32'(u_if.out_alu_ctrl), 32'd3);
    chk("t1_imm", 32'(u_if.out_imm_type), 32'd1);
    chk("t1_src2", 32'(u_if.out_alu_src2), 32'd2);
    chk("t1_src1", 32'(u_if.out_alu_src1), 32'd0);
    chk("t1_regwr", 32'(u_if.out_reg_write), 32'd3);
    tick();
    chk("t1_drain", 32'(u_if.out_valid), 32'd0);

    // T2: backpressure, full queue, order preserved
    u_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      u_if.in_valid = 1'b1;
      u_if.in_instr = 32'h13 | (32'(k + 1) << 7);
      u_if.in_pc    = 32'h200 + 32'(4 * k);
      tick();
    end
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_in_ready", 32'(u_if.in_ready), 32'd0);
    chk("t2_valid", 32'(u_if.out_valid), 32'd1);
    u_if.in_instr = 32'h00000313; u_if.in_pc = 32'h300;
    tick();
    u_if.in_valid = 1'b0;
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_hold_pc", u_if.out_pc, 32'h200);
    chk("t2_hold_rd", 32'(u_if.out_rd), 32'd1);
    u_if.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("t2_order_pc", u_if.out_pc, 32'h200 + 32'(4 * k));
      chk("t2_order_rd", 32'(u_if.out_rd), 32'(k + 1));
    end
    tick();
    chk("t2_empty", 32'(u_if.out_valid), 32'd0);

    // T3: sub x3,x1,x2 and the all-zero word
    send(32'h402081B3, 32'h400);
    chk("t3_alu", 32'(u_if.out_alu_ctrl), 32'd4);
    chk("t3_rread", 32'(u_if.out_reg_read), 32'd3);
    chk("t3_rd", 32'(u_if.out_rd), 32'd3);
    chk("t3_rs1", 32'(u_if.out_rs1), 32'd1);
    chk("t3_rs2", 32'(u_if.out_rs2), 32'd2);
    chk("t3_illegal_sub", 32'(u_if.out_illegal), 32'd0);
    send(32'h00000000, 32'h404);
    chk("t3_zero_valid", 32'(u_if.out_valid), 32'd1);
    chk("t3_zero_writes", {25'd0, u_if.out_illegal, u_if.out_reg_write, u_if.out_mem_write[2:0]},
        {25'd0, 1'b1, 3'd0, 3'd0});
    chk("t3_zero_ctl", {26'd0, u_if.out_mem_write[3], u_if.out_branch_type, u_if.out_jal, u_if.out_jalr},
        32'd0);
    chk("t3_zero_m2r", 32'(u_if.out_mem_to_reg), 32'd0);

    // decode table
    for (int k = 0; k < 9; k++) begin
      send(TV_INS[k], 32'h500 + 32'(4 * k));
      chk($sformatf("tbl%0d", k),
          32'({u_if.out_illegal, u_if.out_reg_write, u_if.out_mem_write,
               u_if.out_branch_type, u_if.out_alu_ctrl}),
          32'(TV_EXP[k]));
    end
    chk("tbl_jalr_npc", 32'({u_if.out_jalr, u_if.out_load_npc}), 32'd0);
    send(32'h000100E7, 32'h600);
    chk("jalr_flags", 32'({u_if.out_jalr, u_if.out_load_npc, u_if.out_alu_src1}), 32'd7);

    // T4: flush with a concurrent push
    tick();
    u_if.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      u_if.in_valid = 1'b1;
      u_if.in_instr = 32'h00000013;
      u_if.in_pc    = 32'h700 + 32'(4 * k);
      tick();
    end
    chk("t4_count", 32'(count), 32'd3);
    flush = 1'b1;
    u_if.in_instr = 32'h00100113; u_if.in_pc = 32'hDEAD0;
    tick();
    flush = 1'b0; u_if.in_valid = 1'b0;
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_valid0", 32'(u_if.out_valid), 32'd0);
    chk("t4_in_ready", 32'(u_if.in_ready), 32'd1);
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_emerge", 32'(u_if.out_valid), 32'd0);
    end

    // T5: mul x5,x6,x7
    send(32'h027302B3, 32'h800);
    chk("t5_rd", 32'(u_if.out_rd), 32'd5);
`ifdef RV32M_EN
    chk("t5_md_op", 32'(u_if.out_md_op), 32'h8);
    chk("t5_illegal", 32'(u_if.out_illegal), 32'd0);
    chk("t5_regwr", 32'(u_if.out_reg_write), 32'd3);
`else
    chk("t5_md_op", 32'(u_if.out_md_op), 32'h0);
    chk("t5_illegal", 32'(u_if.out_illegal), 32'd1);
    chk("t5_regwr", 32'(u_if.out_reg_write), 32'd0);
`endif

    // reset beats flush and drops everything mid-operation
    send(32'h00500093, 32'h900);
    u_if.out_ready = 1'b0;
    u_if.in_valid = 1'b1; u_if.in_pc = 32'h904;
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; u_if.in_valid = 1'b0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(u_if.out_valid), 32'd0);
    chk("mrst_regwr", 32'(u_if.out_reg_write), 32'd0);

    // T6: streaming 2*DEPTH+1 instrs, one per cycle
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      u_if.in_valid = 1'b1;
      u_if.in_instr = 32'h13 | (32'(k + 1) << 7);
      u_if.in_pc    = 32'h1000 + 32'(4 * k);
      tick();
      if (k > 0) begin
        chk("t6_valid", 32'(u_if.out_valid), 32'd1);
        chk("t6_pc", u_if.out_pc, 32'h1000 + 32'(4 * (k - 1)));
        chk("t6_count", 32'(count), 32'd1);
      end
    end
    u_if.in_valid = 1'b0;
    tick();
    chk("t6_last_pc", u_if.out_pc, 32'h1020);
    chk("t6_last_rd", 32'(u_if.out_rd), 32'd9);
    tick();
    chk("t6_end", 32'(u_if.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
